// File: rtl/axil_gpio_ctrl.sv
// ============================================================================
// Module   : axil_gpio_ctrl
// Brief    : AXI-lite slave with per-core reset control (minimum hold time),
//            read-only reset status and NUM_GPIO 32-bit output registers.
//            Optional byte-lane write strobes: AXIL_GPIO_CTRL_WSTRB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_gpio_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_CORES  = 4,
  parameter int NUM_GPIO   = 2,
  parameter int RST_HOLD   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [31:0]             s_axil_wdata,
  input  logic [3:0]              s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [31:0]             s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic [NUM_CORES-1:0]    core_resetn,
  output logic [32*NUM_GPIO-1:0]  gpio_out
);

  localparam int                  c_idx_w   = ADDR_WIDTH - 2;
  localparam logic [c_idx_w-1:0]  c_idx_ctrl = c_idx_w'(0);
  localparam logic [c_idx_w-1:0]  c_idx_stat = c_idx_w'(1);
  localparam logic [c_idx_w-1:0]  c_num_idx  = c_idx_w'(NUM_GPIO + 2);
  localparam logic [15:0]         c_hold     = 16'(RST_HOLD);
  localparam logic [1:0]          c_okay     = 2'b00;
  localparam logic [1:0]          c_slverr   = 2'b10;

  logic                 awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]           bresp_q, rresp_q;
  logic [31:0]          rdata_q;
  logic [NUM_CORES-1:0] ctrl_q, ctrl_d;

  logic                 w_wr_acc, w_rd_acc, w_aw_hit;
  logic [c_idx_w-1:0]   w_aw_idx, w_ar_idx;
  logic [31:0]          w_wmask, w_rdata_d;
  logic [1:0]           w_rresp_d;
  logic [NUM_GPIO-1:0][31:0] w_gpio;
  logic                 w_unused_addr;

  assign w_aw_idx = s_axil_awaddr[ADDR_WIDTH-1:2];
  assign w_ar_idx = s_axil_araddr[ADDR_WIDTH-1:2];
  assign w_aw_hit = (w_aw_idx < c_num_idx);
  assign w_unused_addr = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

`ifdef AXIL_GPIO_CTRL_WSTRB_EN
  assign w_wmask = {{8{s_axil_wstrb[3]}}, {8{s_axil_wstrb[2]}},
                    {8{s_axil_wstrb[1]}}, {8{s_axil_wstrb[0]}}};
`else
  logic w_unused_strb;
  assign w_unused_strb = ^s_axil_wstrb;
  assign w_wmask       = '1;
`endif

  // AW and W are only taken together, and never while a response is stuck
  assign w_wr_acc = s_axil_awvalid && s_axil_wvalid && !awready_q &&
                    (!bvalid_q || s_axil_bready);
  assign w_rd_acc = s_axil_arvalid && !arready_q && (!rvalid_q || s_axil_rready);

  assign ctrl_d = (ctrl_q & ~w_wmask[NUM_CORES-1:0]) |
                  (s_axil_wdata[NUM_CORES-1:0] & w_wmask[NUM_CORES-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= c_okay;
      ctrl_q    <= '0;
    end else begin
      awready_q <= w_wr_acc;
      wready_q  <= w_wr_acc;
      if (w_wr_acc) begin
        bvalid_q <= 1'b1;
        bresp_q  <= w_aw_hit ? c_okay : c_slverr;
        if (w_aw_idx == c_idx_ctrl) begin
          ctrl_q <= ctrl_d;
        end
      end else if (s_axil_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read mux samples current register state, so same-cycle writes read old data
  always_comb begin
    w_rdata_d = '0;
    w_rresp_d = c_okay;
    if (w_ar_idx == c_idx_ctrl) begin
      w_rdata_d = 32'(ctrl_q);
    end else if (w_ar_idx == c_idx_stat) begin
      w_rdata_d = 32'(core_resetn);
    end else if (w_ar_idx < c_num_idx) begin
      for (int k = 0; k < NUM_GPIO; k++) begin
        if (w_ar_idx == c_idx_w'(k + 2)) begin
          w_rdata_d = w_gpio[k];
        end
      end
    end else begin
      w_rresp_d = c_slverr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= c_okay;
    end else begin
      arready_q <= w_rd_acc;
      if (w_rd_acc) begin
        rvalid_q <= 1'b1;
        rdata_q  <= w_rdata_d;
        rresp_q  <= w_rresp_d;
      end else if (s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_GPIO; k++) begin : g_gpio
    localparam logic [c_idx_w-1:0] c_idx = c_idx_w'(k + 2);
    logic [31:0] gpio_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        gpio_q <= '0;
      end else if (w_wr_acc && (w_aw_idx == c_idx)) begin
        gpio_q <= (gpio_q & ~w_wmask) | (s_axil_wdata & w_wmask);
      end
    end

    assign w_gpio[k] = gpio_q;
  end

  // Release only after the counter has saturated; clearing CTRL restarts the hold
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    logic [15:0] hold_q, hold_d;
    logic        rel_q, rel_d;

    always_comb begin
      hold_d = hold_q;
      rel_d  = rel_q;
      if (!ctrl_q[i]) begin
        hold_d = '0;
        rel_d  = 1'b0;
      end else if (!rel_q) begin
        if (hold_q == c_hold) begin
          rel_d = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q <= '0;
        rel_q  <= 1'b0;
      end else begin
        hold_q <= hold_d;
        rel_q  <= rel_d;
      end
    end

    assign core_resetn[i] = rel_q;
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign gpio_out       = w_gpio;

endmodule

`default_nettype wire

// File: tb/tb_axil_gpio_ctrl.sv
// ============================================================================
// Module   : tb_axil_gpio_ctrl
// Brief    : Vector-table and directed-sequence bench for axil_gpio_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_gpio_ctrl;

  localparam int RST_HOLD = 16;
`ifdef AXIL_GPIO_CTRL_WSTRB_EN
  localparam logic [31:0] EXP_STRB = 32'h11BB33DD;
`else
  localparam logic [31:0] EXP_STRB = 32'hAABBCCDD;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [3:0]  core_resetn;
  logic [63:0] gpio_out;

  axil_gpio_ctrl #(
    .ADDR_WIDTH(32), .NUM_CORES(4), .NUM_GPIO(2), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
    .s_axil_wready(wready), .s_axil_bresp(bresp), .s_axil_bvalid(bvalid),
    .s_axil_bready(bready), .s_axil_araddr(araddr), .s_axil_arvalid(arvalid),
    .s_axil_arready(arready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .core_resetn(core_resetn), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  // Glitch monitors on core 0 (high while expected low, low while expected high)
  logic mon_hi_en = 1'b0, mon_lo_en = 1'b0;
  int   hi_seen = 0, lo_seen = 0, odd_hi = 0;
  always @(negedge clk) begin
    if (mon_hi_en && core_resetn[0]) hi_seen++;
    if (mon_lo_en && !core_resetn[0]) lo_seen++;
    if (!rst && (core_resetn[1] || core_resetn[3])) odd_hi++;
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    string       name;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int tacc);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    do begin wait_edge(); n++; end while (!(awready && wready) && n < 50);
    tacc = cyc;
    chk("wr_accept", {63'd0, awready && wready}, 64'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin wait_edge(); n++; end
    chk("wr_bvalid", {63'd0, bvalid}, 64'd1);
    resp = bresp;
    wait_edge();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    do begin wait_edge(); n++; end while (!arready && n < 50);
    chk("rd_accept", {63'd0, arready}, 64'd1);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin wait_edge(); n++; end
    chk("rd_rvalid", {63'd0, rvalid}, 64'd1);
    d = rdata; resp = rresp;
    wait_edge();
    rready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [1:0]  resp;
  logic [31:0] rd;
  int          t0, trel, n, held;

  initial begin
    vecs[0]  = '{1'b0, 32'h00, 32'h0, 4'h0, 32'h0,        2'b00, "rd_ctrl_rst"};
    vecs[1]  = '{1'b0, 32'h04, 32'h0, 4'h0, 32'h0,        2'b00, "rd_stat_rst"};
    vecs[2]  = '{1'b0, 32'h08, 32'h0, 4'h0, 32'h0,        2'b00, "rd_gpio0_rst"};
    vecs[3]  = '{1'b0, 32'h0C, 32'h0, 4'h0, 32'h0,        2'b00, "rd_gpio1_rst"};
    vecs[4]  = '{1'b0, 32'h20, 32'h0, 4'h0, 32'h0,        2'b10, "rd_bad_idx"};
    vecs[5]  = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b10, "wr_bad_idx"};
    vecs[6]  = '{1'b1, 32'h04, 32'h0000000F, 4'hF, 32'h0, 2'b00, "wr_status"};
    vecs[7]  = '{1'b0, 32'h04, 32'h0, 4'h0, 32'h0,        2'b00, "rd_stat_after_wr"};
    vecs[8]  = '{1'b1, 32'h08, 32'h11223344, 4'hF, 32'h0, 2'b00, "wr_gpio0"};
    vecs[9]  = '{1'b0, 32'h0B, 32'h0, 4'h0, 32'h11223344, 2'b00, "rd_gpio0_lowbits"};
    vecs[10] = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 32'h0, 2'b00, "wr_gpio0_strb"};
    vecs[11] = '{1'b0, 32'h08, 32'h0, 4'h0, EXP_STRB,     2'b00, "rd_gpio0_strb"};
    vecs[12] = '{1'b0, 32'h20, 32'h0, 4'h0, 32'h0,        2'b10, "rd_bad_again"};
    vecs[13] = '{1'b0, 32'h00, 32'h0, 4'h0, 32'h0,        2'b00, "rd_ctrl_unchanged"};

    rst = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) wait_edge();
    rst = 1'b0;
    wait_edge();

    chk("rst_core_resetn", {60'd0, core_resetn}, 64'd0);
    chk("rst_gpio_out", gpio_out, 64'd0);
    chk("rst_handshakes", {59'd0, awready, wready, arready, bvalid, rvalid}, 64'd0);
    chk("rst_resp_data", {30'd0, bresp, rresp, rdata}, 64'd0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, t0);
        chk(vecs[i].name, {62'd0, resp}, {62'd0, vecs[i].exp_resp});
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        chk(vecs[i].name, {30'd0, resp, rd}, {30'd0, vecs[i].exp_resp, vecs[i].exp_data});
      end
    end
    chk("gpio_out_after_table", gpio_out, {32'h0, EXP_STRB});
    chk("cores_after_table", {60'd0, core_resetn}, 64'd0);

    // CTRL=0x5: cores 0 and 2 released only after the hold time
    axi_write(32'h0, 32'h5, 4'hF, resp, t0);
    n = 0;
    while (core_resetn[0] !== 1'b1 && n < 60) begin wait_edge(); n++; end
    trel = cyc;
    chk("hold_min_c0", {63'd0, (trel - t0) >= RST_HOLD}, 64'd1);
    chk("hold_max_c0", {63'd0, (trel - t0) <= RST_HOLD + 3}, 64'd1);
    chk("released_0101", {60'd0, core_resetn}, 64'h5);
    axi_read(32'h04, rd, resp);
    chk("rd_status_5", {30'd0, resp, rd}, 64'h5);

    // Set, abort early, set again: fresh hold and no early high pulse
    axi_write(32'h0, 32'h0, 4'hF, resp, t0);
    chk("ctrl_clear_resets", {60'd0, core_resetn}, 64'd0);
    hi_seen = 0;
    mon_hi_en = 1'b1;
    axi_write(32'h0, 32'h1, 4'hF, resp, t0);
    repeat (5) wait_edge();
    axi_write(32'h0, 32'h0, 4'hF, resp, t0);
    axi_write(32'h0, 32'h1, 4'hF, resp, t0);
    n = 0;
    while (core_resetn[0] !== 1'b1 && n < 60) begin wait_edge(); n++; end
    mon_hi_en = 1'b0;
    trel = cyc;
    chk("no_early_pulse", hi_seen, 64'd0);
    chk("rehold_min", {63'd0, (trel - t0) >= RST_HOLD}, 64'd1);
    chk("rehold_max", {63'd0, (trel - t0) <= RST_HOLD + 3}, 64'd1);

    // Rewrite CTRL=1 while released: must stay high
    lo_seen = 0;
    mon_lo_en = 1'b1;
    axi_write(32'h0, 32'h1, 4'hF, resp, t0);
    repeat (20) wait_edge();
    mon_lo_en = 1'b0;
    chk("rewrite_no_glitch", lo_seen, 64'd0);
    chk("rewrite_state", {60'd0, core_resetn}, 64'h1);

    // GPIO1 write with B held off 10 cycles while a second write waits
    awaddr = 32'h0C; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin wait_edge(); n++; end while (!awready && n < 50);
    chk("hold_wr_accept", {63'd0, awready}, 64'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("gpio1_deadbeef", {32'd0, gpio_out[63:32]}, 64'hDEADBEEF);
    awaddr = 32'h08; wdata = 32'h00000055; awvalid = 1'b1; wvalid = 1'b1;
    held = 0;
    repeat (10) begin
      wait_edge();
      if (bvalid && !awready) held++;
    end
    chk("bvalid_held_no_accept", held, 64'd10);
    chk("second_wr_blocked", {32'd0, gpio_out[31:0]}, {32'd0, EXP_STRB});
    bready = 1'b1;
    n = 0;
    do begin wait_edge(); n++; end while (!awready && n < 50);
    chk("second_wr_accept", {63'd0, awready}, 64'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin wait_edge(); n++; end
    chk("second_wr_bresp", {61'd0, bvalid, bresp}, 64'h4);
    wait_edge();
    bready = 1'b0;
    chk("gpio0_55", {32'd0, gpio_out[31:0]}, 64'h55);
    axi_read(32'h0C, rd, resp);
    chk("rd_gpio1_deadbeef", {30'd0, resp, rd}, 64'hDEADBEEF);

    // Simultaneous read and write of the same register returns the old value
    awaddr = 32'h08; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 32'h08; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    do begin wait_edge(); n++; end while (!arready && n < 50);
    chk("rw_same_cycle", {62'd0, arready, awready}, 64'h3);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n = 0;
    while (!(rvalid && bvalid) && n < 50) begin wait_edge(); n++; end
    chk("rd_old_value", {30'd0, rresp, rdata}, 64'h55);
    wait_edge();
    bready = 1'b0; rready = 1'b0;
    axi_read(32'h08, rd, resp);
    chk("rd_new_value", {30'd0, resp, rd}, 64'h77);

    // Reset in the middle of a pending response
    awaddr = 32'h0C; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin wait_edge(); n++; end while (!awready && n < 50);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pre_rst_bvalid", {63'd0, bvalid}, 64'd1);
    rst = 1'b1;
    wait_edge();
    chk("rst_mid_handshakes", {59'd0, awready, wready, arready, bvalid, rvalid}, 64'd0);
    chk("rst_mid_cores", {60'd0, core_resetn}, 64'd0);
    chk("rst_mid_gpio", gpio_out, 64'd0);
    rst = 1'b0;
    wait_edge();

    chk("odd_cores_never_high", odd_hi, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axil_gpio_ctrl.md
Name: axil_gpio_ctrl

Overview:
- Parametrised AXI-lite control/GPIO slave. It is the successor to the single write-only GPIO register that drives one CPU resetn.
- Provides NUM_CORES per-core reset controls with a guaranteed minimum reset-hold time, read-only status, NUM_GPIO general-purpose output registers, and full read-back.
- Sits on an m0x port of the external-side AXI-lite interconnect in multi-core grid tiles; core_resetn[i] feeds each picorv32_axi resetn.

Parameters:
- ADDR_WIDTH, 32, AXI-lite address width.
- NUM_CORES, 4, number of reset outputs (1..32).
- NUM_GPIO, 2, number of 32-bit GPIO registers (>=1).
- RST_HOLD, 16, minimum cycles core_resetn[i] stays low before release (0..65535).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_awvalid  in  1 / s_axil_awready  out  1
- s_axil_wdata  in  32 / s_axil_wstrb  in  4 / s_axil_wvalid  in  1 / s_axil_wready  out  1
- s_axil_bresp  out  2 / s_axil_bvalid  out  1 / s_axil_bready  in  1
- s_axil_araddr  in  ADDR_WIDTH / s_axil_arvalid  in  1 / s_axil_arready  out  1
- s_axil_rdata  out  32 / s_axil_rresp  out  2 / s_axil_rvalid  out  1 / s_axil_rready  in  1
- core_resetn  out  NUM_CORES  per-core active-low reset
- gpio_out  out  32*NUM_GPIO  GPIO register contents, reg k at [32k+31:32k]

Behaviour:
- One clock, clk. Reset rst is synchronous, active-high.
- Register map (word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored):
  - 0 CTRL: R/W; bits[NUM_CORES-1:0] are the resetn requests; upper bits read 0.
  - 1 STATUS: RO; bits[NUM_CORES-1:0] = core_resetn; writes are ignored with OKAY response.
  - 2..NUM_GPIO+1: GPIO, R/W, 32 bits.
  - Index >= NUM_GPIO+2: write ignored, bresp=2'b10 (SLVERR); read returns rdata=0, rresp=2'b10.
- Reset values: all registers 0; core_resetn=0; gpio_out=0; awready=wready=arready=0; bvalid=rvalid=0; bresp=rresp=0; rdata=0; hold counters=0.
- Write channel:
  - Accept when awvalid && wvalid && !awready && (!bvalid || bready).
  - On accept, awready and wready pulse high together for exactly 1 cycle, the register updates, and bvalid rises the next edge.
  - bvalid holds until bready.
  - AW without W (or W without AW) waits; there is no partial acceptance.
- Read channel:
  - Accept when arvalid && !arready && (!rvalid || rready).
  - On accept, arready pulses for 1 cycle; rdata/rresp are registered and rvalid rises the next edge, holding until rready.
  - Back-to-back reads complete once every 2 cycles.
- Read/write ordering:
  - Read and write channels are independent and may complete in the same cycle.
  - A read of a register written in the same cycle returns the old value.
- Reset sequencing, per core i, with a 16-bit saturating counter hold_cnt[i]:
  - While core_resetn[i]=0, hold_cnt increments, saturating at RST_HOLD.
  - core_resetn[i] rises on the edge where CTRL[i]=1 and hold_cnt[i]==RST_HOLD.
  - CTRL[i]=0 forces core_resetn[i]=0 the edge after the write, and clears hold_cnt[i] to 0.
  - RST_HOLD=0: release occurs 1 cycle after CTRL[i] is set.
  - CTRL[i] set then cleared before the hold expires: the core stays in reset and the counter restarts.
  - Rewriting CTRL[i]=1 while already released: no effect, no glitch.
- rst asserted mid-transaction: all handshakes drop next edge, the pending response is discarded, and all cores re-enter reset.

Optional Feature:
- Macro: AXIL_GPIO_CTRL_WSTRB_EN.
- Defined: writes honour s_axil_wstrb per byte lane; a lane with strobe 0 keeps its old byte; CTRL uses the same rule.
- Undefined: wstrb is ignored and all 4 bytes are written.

Test Plan:
- Reset, then read idx 0..3 (NUM_GPIO=2) -> rdata=0, rresp=0; core_resetn=4'b0000.
- Write CTRL=0x5 with RST_HOLD=16 -> core_resetn stays 0 until the hold expires, then becomes 4'b0101; STATUS reads 0x5; cores 1 and 3 stay 0.
- Write CTRL=0x1 for 5 cycles, then CTRL=0x0, then CTRL=0x1 -> core 0 is released only after a fresh 16-cycle hold; no pulse high in between.
- Write GPIO idx 3 = 0xDEADBEEF, hold bready=0 for 10 cycles -> bvalid held, no second accept; gpio_out[63:32]=0xDEADBEEF; readback matches.
- Write/read idx 8 -> bresp=2'b10, rresp=2'b10, rdata=0; no register changes.
- With AXIL_GPIO_CTRL_WSTRB_EN: GPIO idx 2 = 0x11223344, then write 0xAABBCCDD with wstrb=4'b0101 -> reads 0x11BB33DD. Without the macro -> reads 0xAABBCCDD.
